// File: rtl/id_hazard_scoreboard_if.sv
// Decode-stage hazard/forwarding bus between decode logic and the scoreboard.
// With HAZARD_PERF_EN defined the bus also carries the stall-cycle counter.
interface id_hazard_scoreboard_if #(
    parameter int RADDR_WIDTH = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_FWD     = 2,
    parameter int LAT_WIDTH   = 3
);
    logic                          hold_i;
    logic                          flush_i;
    logic                          id_valid_i;
    logic                          reg1_re_i;
    logic                          reg2_re_i;
    logic [RADDR_WIDTH-1:0]        reg1_raddr_i;
    logic [RADDR_WIDTH-1:0]        reg2_raddr_i;
    logic [DATA_WIDTH-1:0]         reg1_rdata_i;
    logic [DATA_WIDTH-1:0]         reg2_rdata_i;
    logic                          issue_we_i;
    logic [RADDR_WIDTH-1:0]        issue_waddr_i;
    logic [LAT_WIDTH-1:0]          issue_lat_i;
    logic [NUM_FWD-1:0]            fwd_we_i;
    logic [NUM_FWD*RADDR_WIDTH-1:0] fwd_waddr_i;
    logic [NUM_FWD*DATA_WIDTH-1:0]  fwd_wdata_i;
    logic [DATA_WIDTH-1:0]         op1_o;
    logic [DATA_WIDTH-1:0]         op2_o;
    logic                          stallreq_o;
`ifdef HAZARD_PERF_EN
    logic                          perf_clr_i;
    logic [31:0]                   stall_cycles_o;

    modport master (
        output hold_i, flush_i, id_valid_i, reg1_re_i, reg2_re_i,
        output reg1_raddr_i, reg2_raddr_i, reg1_rdata_i, reg2_rdata_i,
        output issue_we_i, issue_waddr_i, issue_lat_i,
        output fwd_we_i, fwd_waddr_i, fwd_wdata_i, perf_clr_i,
        input  op1_o, op2_o, stallreq_o, stall_cycles_o
    );

    modport slave (
        input  hold_i, flush_i, id_valid_i, reg1_re_i, reg2_re_i,
        input  reg1_raddr_i, reg2_raddr_i, reg1_rdata_i, reg2_rdata_i,
        input  issue_we_i, issue_waddr_i, issue_lat_i,
        input  fwd_we_i, fwd_waddr_i, fwd_wdata_i, perf_clr_i,
        output op1_o, op2_o, stallreq_o, stall_cycles_o
    );
`else
    modport master (
        output hold_i, flush_i, id_valid_i, reg1_re_i, reg2_re_i,
        output reg1_raddr_i, reg2_raddr_i, reg1_rdata_i, reg2_rdata_i,
        output issue_we_i, issue_waddr_i, issue_lat_i,
        output fwd_we_i, fwd_waddr_i, fwd_wdata_i,
        input  op1_o, op2_o, stallreq_o
    );

    modport slave (
        input  hold_i, flush_i, id_valid_i, reg1_re_i, reg2_re_i,
        input  reg1_raddr_i, reg2_raddr_i, reg1_rdata_i, reg2_rdata_i,
        input  issue_we_i, issue_waddr_i, issue_lat_i,
        input  fwd_we_i, fwd_waddr_i, fwd_wdata_i,
        output op1_o, op2_o, stallreq_o
    );
`endif
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage per-register latency scoreboard with prioritised forwarding.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_EN.
module id_hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_FWD     = 2,
    parameter int LAT_WIDTH   = 3
) (
    input logic                  clk_i,
    input logic                  rst_i,
    id_hazard_scoreboard_if.slave bus
);
    // x0 has no counter; index range starts at 1
    logic [LAT_WIDTH-1:0] cnt_q [1:NUM_REGS-1];
    logic [LAT_WIDTH-1:0] cnt_d [1:NUM_REGS-1];

    logic busy1;
    logic busy2;
    logic stall;
    logic issue_fire;

    // Look up pending latency for each source; unmatched addresses read as idle
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (bus.reg1_raddr_i == RADDR_WIDTH'(r) && cnt_q[r] != '0)
                busy1 = 1'b1;
            if (bus.reg2_raddr_i == RADDR_WIDTH'(r) && cnt_q[r] != '0)
                busy2 = 1'b1;
        end
        stall = bus.id_valid_i &
                ((bus.reg1_re_i & busy1) | (bus.reg2_re_i & busy2));
    end

    assign issue_fire = bus.id_valid_i & ~stall & ~bus.hold_i & ~bus.flush_i;
    assign bus.stallreq_o = stall;

    // Next counter values: a firing issue reloads, otherwise count down to 0
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue_fire && bus.issue_we_i &&
                bus.issue_waddr_i == RADDR_WIDTH'(r))
                cnt_d[r] = bus.issue_lat_i;
            else if (cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - 1'b1;
        end
    end

    // Latency counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 1; r < NUM_REGS; r++)
                cnt_q[r] <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++)
                cnt_q[r] <= cnt_d[r];
        end
    end

    // rs1 operand: x0/disabled read zero, else lowest-index matching source wins
    always_comb begin
        bus.op1_o = '0;
        if (bus.reg1_re_i && bus.reg1_raddr_i != '0) begin
            bus.op1_o = bus.reg1_rdata_i;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (bus.fwd_we_i[k] &&
                    bus.fwd_waddr_i[k*RADDR_WIDTH +: RADDR_WIDTH] == bus.reg1_raddr_i)
                    bus.op1_o = bus.fwd_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // rs2 operand: same resolution as rs1
    always_comb begin
        bus.op2_o = '0;
        if (bus.reg2_re_i && bus.reg2_raddr_i != '0) begin
            bus.op2_o = bus.reg2_rdata_i;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (bus.fwd_we_i[k] &&
                    bus.fwd_waddr_i[k*RADDR_WIDTH +: RADDR_WIDTH] == bus.reg2_raddr_i)
                    bus.op2_o = bus.fwd_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    // Count unheld stall cycles, saturating; clear wins over increment
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (bus.perf_clr_i)
            stall_cycles_d = '0;
        else if (stall && !bus.hold_i && stall_cycles_q != 32'hFFFF_FFFF)
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    // Stall-cycle counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_cycles_q <= '0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign bus.stall_cycles_o = stall_cycles_q;
`endif
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Scoreboard-driven bench for id_hazard_scoreboard.
// Expected values are queued with the stimulus and checked at the falling edge.
module tb_id_hazard_scoreboard;
    localparam int RW = 5;
    localparam int DW = 32;
    localparam int NF = 2;
    localparam int LW = 3;

    localparam int S_STALL = 0;
    localparam int S_OP1   = 1;
    localparam int S_OP2   = 2;
    localparam int S_PERF  = 3;

    logic clk;
    logic rst;

    id_hazard_scoreboard_if #(
        .RADDR_WIDTH(RW), .DATA_WIDTH(DW), .NUM_FWD(NF), .LAT_WIDTH(LW)
    ) bus ();

    id_hazard_scoreboard #(
        .NUM_REGS(32), .RADDR_WIDTH(RW), .DATA_WIDTH(DW),
        .NUM_FWD(NF), .LAT_WIDTH(LW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        logic [31:0] v;
        v = '0;
        case (sel)
            S_STALL: v = {31'd0, bus.stallreq_o};
            S_OP1:   v = bus.op1_o;
            S_OP2:   v = bus.op2_o;
`ifdef HAZARD_PERF_EN
            S_PERF:  v = bus.stall_cycles_o;
`endif
            default: v = 'x;
        endcase
        return v;
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic sample_now();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        sample_now();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic zero();
        bus.hold_i        = 1'b0;
        bus.flush_i       = 1'b0;
        bus.id_valid_i    = 1'b0;
        bus.reg1_re_i     = 1'b0;
        bus.reg2_re_i     = 1'b0;
        bus.reg1_raddr_i  = '0;
        bus.reg2_raddr_i  = '0;
        bus.reg1_rdata_i  = '0;
        bus.reg2_rdata_i  = '0;
        bus.issue_we_i    = 1'b0;
        bus.issue_waddr_i = '0;
        bus.issue_lat_i   = '0;
        bus.fwd_we_i      = '0;
        bus.fwd_waddr_i   = '0;
        bus.fwd_wdata_i   = '0;
`ifdef HAZARD_PERF_EN
        bus.perf_clr_i    = 1'b0;
`endif
    endtask

    task automatic issue(input logic [RW-1:0] rd, input logic [LW-1:0] lat);
        bus.id_valid_i    = 1'b1;
        bus.issue_we_i    = 1'b1;
        bus.issue_waddr_i = rd;
        bus.issue_lat_i   = lat;
    endtask

    task automatic rd1(input logic [RW-1:0] a, input logic [DW-1:0] d);
        bus.id_valid_i   = 1'b1;
        bus.reg1_re_i    = 1'b1;
        bus.reg1_raddr_i = a;
        bus.reg1_rdata_i = d;
    endtask

    task automatic rd2(input logic [RW-1:0] a, input logic [DW-1:0] d);
        bus.id_valid_i   = 1'b1;
        bus.reg2_re_i    = 1'b1;
        bus.reg2_raddr_i = a;
        bus.reg2_rdata_i = d;
    endtask

    task automatic fwd(input int k, input logic [RW-1:0] a,
                       input logic [DW-1:0] d);
        bus.fwd_we_i[k]                 = 1'b1;
        bus.fwd_waddr_i[k*RW +: RW]     = a;
        bus.fwd_wdata_i[k*DW +: DW]     = d;
    endtask

    initial begin
        zero();
        rst = 1'b1;
        rd1(5'd5, 32'h1234);
        rd2(5'd6, 32'h5678);
        push("rst_stall", S_STALL, 32'd0);
`ifdef HAZARD_PERF_EN
        push("rst_perf", S_PERF, 32'd0);
`endif
        sample();
        bus.reg1_re_i = 1'b0;
        bus.reg2_re_i = 1'b0;
        push("rst_op1_nore", S_OP1, 32'd0);
        push("rst_op2_nore", S_OP2, 32'd0);
        sample();
        cyc();
        rst = 1'b0;

        // idle read
        cyc(); zero();
        rd1(5'd5, 32'h1234);
        push("idle_stall", S_STALL, 32'd0);
        push("idle_op1", S_OP1, 32'h1234);
        sample();

        // load-use: rd=3 lat=1
        cyc(); zero();
        issue(5'd3, 3'd1);
        push("lu_issue_stall", S_STALL, 32'd0);
        sample();
        cyc(); zero();
        rd2(5'd3, 32'h2222);
        push("lu_stall1", S_STALL, 32'd1);
        push("lu_op2_rf", S_OP2, 32'h2222);
        sample();
        cyc(); zero();
        rd2(5'd3, 32'h2222);
        fwd(1, 5'd3, 32'hCAFE);
        push("lu_stall_end", S_STALL, 32'd0);
        push("lu_op2_fwd", S_OP2, 32'hCAFE);
        sample();

        // rd=7 lat=4 with hold in the 2nd stall cycle
        cyc(); zero();
        issue(5'd7, 3'd4);
        push("l4_issue", S_STALL, 32'd0);
        sample();
        for (int c = 1; c <= 4; c++) begin
            cyc(); zero();
            rd1(5'd7, 32'h7777);
            issue(5'd11, 3'd2);
            bus.hold_i = (c == 2);
            push($sformatf("l4_stall_c%0d", c), S_STALL, 32'd1);
            sample();
        end
        // stall over, but hold blocks an issue of rd=10
        cyc(); zero();
        rd1(5'd7, 32'h7777);
        issue(5'd10, 3'd2);
        bus.hold_i = 1'b1;
        push("l4_free", S_STALL, 32'd0);
        push("l4_op1", S_OP1, 32'h7777);
        sample();
        // rd=10 never armed; this one issues rd=11 lat=2
        cyc(); zero();
        rd1(5'd10, 32'h1010);
        issue(5'd11, 3'd2);
        push("hold_blocked", S_STALL, 32'd0);
        sample();
        for (int c = 1; c <= 2; c++) begin
            cyc(); zero();
            rd1(5'd11, 32'h0);
            push($sformatf("l2_stall_c%0d", c), S_STALL, 32'd1);
            sample();
        end
        cyc(); zero();
        rd1(5'd11, 32'h0);
        push("l2_free", S_STALL, 32'd0);
        sample();

        // forwarding priority
        cyc(); zero();
        rd1(5'd9, 32'h1111);
        rd2(5'd9, 32'h2222);
        fwd(0, 5'd9, 32'hAAAA);
        fwd(1, 5'd9, 32'hBBBB);
        push("prio_op1", S_OP1, 32'hAAAA);
        push("prio_op2", S_OP2, 32'hAAAA);
        sample();
        cyc(); zero();
        rd1(5'd9, 32'h1111);
        fwd(0, 5'd5, 32'hAAAA);
        fwd(1, 5'd9, 32'hBBBB);
        push("src1_op1", S_OP1, 32'hBBBB);
        sample();
        cyc(); zero();
        fwd(0, 5'd9, 32'hAAAA);
        bus.reg1_raddr_i = 5'd9;
        bus.reg1_rdata_i = 32'h1111;
        push("nore_op1", S_OP1, 32'd0);
        sample();

        // x0 handling
        cyc(); zero();
        issue(5'd0, 3'd3);
        sample();
        cyc(); zero();
        rd1(5'd0, 32'h5555);
        fwd(0, 5'd0, 32'hFFFF);
        push("x0_stall", S_STALL, 32'd0);
        push("x0_op1", S_OP1, 32'd0);
        sample();

        // flush blocks issue
        cyc(); zero();
        issue(5'd4, 3'd2);
        bus.flush_i = 1'b1;
        sample();
        cyc(); zero();
        rd1(5'd4, 32'h4444);
        push("flush_stall", S_STALL, 32'd0);
        push("flush_op1", S_OP1, 32'h4444);
        sample();

        // lat=0 leaves no state
        cyc(); zero();
        issue(5'd6, 3'd0);
        sample();
        cyc(); zero();
        rd1(5'd6, 32'h6666);
        fwd(0, 5'd6, 32'h0606);
        push("lat0_stall", S_STALL, 32'd0);
        push("lat0_op1", S_OP1, 32'h0606);
        sample();

        // invalid decode never stalls; then reset mid-stall
        cyc(); zero();
        issue(5'd13, 3'd5);
        sample();
        cyc(); zero();
        bus.reg1_re_i    = 1'b1;
        bus.reg1_raddr_i = 5'd13;
        push("novalid_stall", S_STALL, 32'd0);
        sample();
        cyc(); zero();
        rd1(5'd13, 32'h0);
        push("pre_rst_stall", S_STALL, 32'd1);
        sample();
        #1 rst = 1'b1;
        #1;
        push("mid_rst_stall", S_STALL, 32'd0);
        sample_now();
        cyc();
        rst = 1'b0;
        cyc(); zero();
        rd1(5'd13, 32'h0);
        push("post_rst_stall", S_STALL, 32'd0);
        sample();

`ifdef HAZARD_PERF_EN
        cyc(); zero();
        bus.perf_clr_i = 1'b1;
        sample();
        cyc(); zero();
        issue(5'd12, 3'd4);
        push("perf_clr0", S_PERF, 32'd0);
        sample();
        for (int c = 1; c <= 4; c++) begin
            cyc(); zero();
            rd1(5'd12, 32'h0);
            sample();
        end
        cyc(); zero();
        push("perf_cnt4", S_PERF, 32'd4);
        sample();
        cyc(); zero();
        bus.perf_clr_i = 1'b1;
        sample();
        cyc(); zero();
        push("perf_clr", S_PERF, 32'd0);
        sample();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
